// File: rtl/eu_speriph_plug_arbiter.sv
// Round-robin arbiter that merges several speriph plugs into the event unit's
// single peripheral slave port. An ownership FIFO records which plug issued
// each transaction, so each response is routed back to that plug only.
module eu_speriph_plug_arbiter #(
  parameter int NB_PLUGS        = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NB_PLUGS-1:0]                    plug_req_i,
  input  logic [NB_PLUGS-1:0][ADDR_WIDTH-1:0]    plug_add_i,
  input  logic [NB_PLUGS-1:0]                    plug_wen_i,
  input  logic [NB_PLUGS-1:0][DATA_WIDTH-1:0]    plug_wdata_i,
  input  logic [NB_PLUGS-1:0][DATA_WIDTH/8-1:0]  plug_be_i,
  input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]      plug_id_i,
  output logic [NB_PLUGS-1:0]                    plug_gnt_o,
  output logic [NB_PLUGS-1:0]                    plug_r_valid_o,
  output logic [NB_PLUGS-1:0][DATA_WIDTH-1:0]    plug_r_rdata_o,
  output logic [NB_PLUGS-1:0]                    plug_r_opc_o,
  output logic [NB_PLUGS-1:0][ID_WIDTH-1:0]      plug_r_id_o,
  output logic                                   eu_req_o,
  output logic [ADDR_WIDTH-1:0]                  eu_add_o,
  output logic                                   eu_wen_o,
  output logic [DATA_WIDTH-1:0]                  eu_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                eu_be_o,
  output logic [ID_WIDTH-1:0]                    eu_id_o,
  input  logic                                   eu_gnt_i,
  input  logic                                   eu_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                  eu_r_rdata_i,
  input  logic                                   eu_r_opc_i,
  input  logic [ID_WIDTH-1:0]                    eu_r_id_i,
  output logic                                   orphan_rsp_o
);

  localparam int IDX_W = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IDX_W-1:0] LAST_PLUG = IDX_W'(NB_PLUGS - 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_OUTSTANDING);

  // Control state
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             orphan_q, orphan_d;

  // Ownership storage: plug index of each outstanding transaction
  logic [IDX_W-1:0] own_q [MAX_OUTSTANDING];

  logic [IDX_W-1:0] rr_win;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             use_lock;
  logic [IDX_W-1:0] win;
  logic             any_req;
  logic             fifo_full_blk;
  logic             hs;
  logic             pop;
  logic [IDX_W-1:0] head;

  // Round-robin search: first requester at or after rr_q, wrapping around
  always_comb begin
    rr_win = rr_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NB_PLUGS; i++) begin
      cand = IDX_W'((int'(rr_q) + i) % NB_PLUGS);
      if (!found && plug_req_i[cand]) begin
        found  = 1'b1;
        rr_win = cand;
      end
    end
  end

  // A stalled request keeps its winner until the event unit grants it, so a
  // late-arriving plug cannot change the fields mid-handshake.
  assign use_lock      = lock_q & plug_req_i[lock_idx_q];
  assign win           = use_lock ? lock_idx_q : rr_win;
  assign any_req       = |plug_req_i;
  // A response in the same cycle frees a slot, so fullness only blocks
  // when no pop is happening.
  assign fifo_full_blk = (cnt_q == FULL_CNT) & ~eu_r_valid_i;
  assign eu_req_o      = any_req & ~fifo_full_blk;
  assign hs            = eu_req_o & eu_gnt_i;
  assign pop           = eu_r_valid_i & (cnt_q != '0);
  assign head          = own_q[rd_ptr_q];
  assign orphan_rsp_o  = orphan_q;

  // Forward the winning plug's request fields; all zero when nobody requests
  always_comb begin
    eu_add_o   = '0;
    eu_wen_o   = 1'b0;
    eu_wdata_o = '0;
    eu_be_o    = '0;
    eu_id_o    = '0;
    if (any_req) begin
      eu_add_o   = plug_add_i[win];
      eu_wen_o   = plug_wen_i[win];
      eu_wdata_o = plug_wdata_i[win];
      eu_be_o    = plug_be_i[win];
      eu_id_o    = plug_id_i[win];
    end
  end

  // Grant only the winner, and only on a completed handshake
  always_comb begin
    plug_gnt_o = '0;
    if (hs) plug_gnt_o[win] = 1'b1;
  end

  // Route response valid to the recorded owner; payload is broadcast
  always_comb begin
    plug_r_valid_o = '0;
    if (pop) plug_r_valid_o[head] = 1'b1;
    for (int p = 0; p < NB_PLUGS; p++) begin
      plug_r_rdata_o[p] = eu_r_rdata_i;
      plug_r_opc_o[p]   = eu_r_opc_i;
      plug_r_id_o[p]    = eu_r_id_i;
    end
  end

  // Next-state logic for pointer, lock, FIFO bookkeeping and orphan flag
  always_comb begin
    rr_d       = rr_q;
    lock_d     = eu_req_o & ~eu_gnt_i;
    lock_idx_d = eu_req_o ? win : lock_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    orphan_d   = orphan_q | (eu_r_valid_i & (cnt_q == '0));
    if (hs) begin
      rr_d     = (win == LAST_PLUG) ? '0 : win + 1'b1;
      wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      orphan_q   <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      orphan_q   <= orphan_d;
    end
  end

  // Ownership entries need no reset: they are only read while count is non-zero
  always_ff @(posedge clk_i) begin
    if (hs) own_q[wr_ptr_q] <= win;
  end

endmodule

// File: tb/tb_eu_speriph_plug_arbiter.sv
// Directed bench for eu_speriph_plug_arbiter with a queue-based scoreboard.
module tb_eu_speriph_plug_arbiter;

  localparam int NB = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int MO = 2;

  logic                      clk = 1'b0;
  logic                      rst_ni;
  logic [NB-1:0]             plug_req_i;
  logic [NB-1:0][AW-1:0]     plug_add_i;
  logic [NB-1:0]             plug_wen_i;
  logic [NB-1:0][DW-1:0]     plug_wdata_i;
  logic [NB-1:0][DW/8-1:0]   plug_be_i;
  logic [NB-1:0][IW-1:0]     plug_id_i;
  logic [NB-1:0]             plug_gnt_o;
  logic [NB-1:0]             plug_r_valid_o;
  logic [NB-1:0][DW-1:0]     plug_r_rdata_o;
  logic [NB-1:0]             plug_r_opc_o;
  logic [NB-1:0][IW-1:0]     plug_r_id_o;
  logic                      eu_req_o;
  logic [AW-1:0]             eu_add_o;
  logic                      eu_wen_o;
  logic [DW-1:0]             eu_wdata_o;
  logic [DW/8-1:0]           eu_be_o;
  logic [IW-1:0]             eu_id_o;
  logic                      eu_gnt_i;
  logic                      eu_r_valid_i;
  logic [DW-1:0]             eu_r_rdata_i;
  logic                      eu_r_opc_i;
  logic [IW-1:0]             eu_r_id_i;
  logic                      orphan_rsp_o;

  eu_speriph_plug_arbiter #(
    .NB_PLUGS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .plug_req_i(plug_req_i), .plug_add_i(plug_add_i), .plug_wen_i(plug_wen_i),
    .plug_wdata_i(plug_wdata_i), .plug_be_i(plug_be_i), .plug_id_i(plug_id_i),
    .plug_gnt_o(plug_gnt_o), .plug_r_valid_o(plug_r_valid_o),
    .plug_r_rdata_o(plug_r_rdata_o), .plug_r_opc_o(plug_r_opc_o), .plug_r_id_o(plug_r_id_o),
    .eu_req_o(eu_req_o), .eu_add_o(eu_add_o), .eu_wen_o(eu_wen_o),
    .eu_wdata_o(eu_wdata_o), .eu_be_o(eu_be_o), .eu_id_o(eu_id_o),
    .eu_gnt_i(eu_gnt_i), .eu_r_valid_i(eu_r_valid_i), .eu_r_rdata_i(eu_r_rdata_i),
    .eu_r_opc_i(eu_r_opc_i), .eu_r_id_i(eu_r_id_i), .orphan_rsp_o(orphan_rsp_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] vec;
    logic [31:0]   data;
    logic [IW-1:0] id;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  int checks = 0;
  int errors = 0;

  localparam logic [AW-1:0] ADD0 = 32'h1B20_0400;
  localparam logic [AW-1:0] ADD1 = 32'h1B20_0800;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    plug_req_i   = '0;
    eu_gnt_i     = 1'b0;
    eu_r_valid_i = 1'b0;
    eu_r_rdata_i = '0;
    eu_r_opc_i   = 1'b0;
    eu_r_id_i    = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_gnt(input logic [NB-1:0] vec, input int p);
    exp_t e;
    e.vec  = vec;
    e.data = plug_add_i[p];
    e.id   = plug_id_i[p];
    gq.push_back(e);
  endtask

  task automatic push_rsp(input logic [NB-1:0] vec, input logic [31:0] data, input logic [IW-1:0] id);
    exp_t e;
    e.vec  = vec;
    e.data = data;
    e.id   = id;
    rq.push_back(e);
  endtask

  // Monitor: compares every presented grant / response against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (plug_gnt_o != '0) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL gnt_unexpected: got gnt=%b add=0x%0h", plug_gnt_o, eu_add_o);
      end else begin
        e = gq.pop_front();
        if (plug_gnt_o !== e.vec || eu_add_o !== e.data || eu_id_o !== e.id) begin
          errors++;
          $display("FAIL gnt: got gnt=%b add=0x%0h id=%0d expected gnt=%b add=0x%0h id=%0d",
                   plug_gnt_o, eu_add_o, eu_id_o, e.vec, e.data, e.id);
        end
      end
    end
    if (plug_r_valid_o != '0) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got r_valid=%b", plug_r_valid_o);
      end else begin
        e = rq.pop_front();
        if (plug_r_valid_o !== e.vec || plug_r_rdata_o[0] !== e.data || plug_r_rdata_o[1] !== e.data ||
            plug_r_id_o[0] !== e.id || plug_r_id_o[1] !== e.id) begin
          errors++;
          $display("FAIL rsp: got r_valid=%b rdata=0x%0h/0x%0h id=%0d expected r_valid=%b rdata=0x%0h id=%0d",
                   plug_r_valid_o, plug_r_rdata_o[0], plug_r_rdata_o[1], plug_r_id_o[0], e.vec, e.data, e.id);
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    plug_add_i[0]   = ADD0;       plug_add_i[1]   = ADD1;
    plug_id_i[0]    = 5'd3;       plug_id_i[1]    = 5'd7;
    plug_wen_i      = 2'b11;
    plug_wdata_i[0] = 32'h1111_0000; plug_wdata_i[1] = 32'h2222_0000;
    plug_be_i[0]    = 4'hF;       plug_be_i[1]    = 4'hF;
    idle();
    rst_ni = 1'b0;
    step();
    @(negedge clk);
    check("reset_eu_req", 32'(eu_req_o), 32'd0);
    check("reset_orphan", 32'(orphan_rsp_o), 32'd0);
    check("reset_gnt", 32'(plug_gnt_o), 32'd0);
    step();
    rst_ni = 1'b1;

    // Single read from plug 0, response next cycle
    plug_req_i = 2'b01; eu_gnt_i = 1'b1;
    push_gnt(2'b01, 0);
    step();
    idle();
    eu_r_valid_i = 1'b1; eu_r_rdata_i = 32'hDEAD_BEEF; eu_r_id_i = 5'd3;
    push_rsp(2'b01, 32'hDEAD_BEEF, 5'd3);
    step();
    idle();
    step();

    // Both plugs requesting continuously: alternating grants, delayed responses
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) begin
        plug_req_i = 2'b11; eu_gnt_i = 1'b1;
        push_gnt((i % 2 == 0) ? 2'b01 : 2'b10, i % 2);
      end
      if (i > 0) begin
        eu_r_valid_i = 1'b1;
        eu_r_rdata_i = 32'h1000 + 32'(i);
        eu_r_id_i    = ((i - 1) % 2 == 0) ? 5'd3 : 5'd7;
        push_rsp(((i - 1) % 2 == 0) ? 2'b01 : 2'b10, 32'h1000 + 32'(i), eu_r_id_i);
      end
      step();
    end
    idle();
    step();

    // Winner lock: move pointer to plug 1, then stall plug 0 while plug 1 joins
    do_reset();
    plug_req_i = 2'b01; eu_gnt_i = 1'b1;
    push_gnt(2'b01, 0);
    step();
    idle();
    eu_r_valid_i = 1'b1; eu_r_rdata_i = 32'h5; eu_r_id_i = 5'd3;
    push_rsp(2'b01, 32'h5, 5'd3);
    step();
    idle();
    plug_req_i = 2'b01;
    @(negedge clk);
    check("lock_add_c0", eu_add_o, ADD0);
    step();
    plug_req_i = 2'b11;
    @(negedge clk);
    check("lock_add_c1", eu_add_o, ADD0);
    step();
    @(negedge clk);
    check("lock_add_c2", eu_add_o, ADD0);
    step();
    eu_gnt_i = 1'b1;
    push_gnt(2'b01, 0);
    step();
    plug_req_i = 2'b10;
    push_gnt(2'b10, 1);
    step();

    // FIFO full (2 outstanding): requests blocked until a response frees a slot
    plug_req_i = 2'b11; eu_gnt_i = 1'b1;
    @(negedge clk);
    check("full_eu_req", 32'(eu_req_o), 32'd0);
    check("full_gnt", 32'(plug_gnt_o), 32'd0);
    step();
    eu_r_valid_i = 1'b1; eu_r_rdata_i = 32'hA; eu_r_id_i = 5'd3;
    push_gnt(2'b01, 0);
    push_rsp(2'b01, 32'hA, 5'd3);
    @(negedge clk);
    check("full_pop_eu_req", 32'(eu_req_o), 32'd1);
    step();
    idle();
    eu_r_valid_i = 1'b1; eu_r_rdata_i = 32'hB; eu_r_id_i = 5'd7;
    push_rsp(2'b10, 32'hB, 5'd7);
    step();
    eu_r_rdata_i = 32'hC; eu_r_id_i = 5'd3;
    push_rsp(2'b01, 32'hC, 5'd3);
    step();
    idle();
    @(negedge clk);
    check("drained_orphan", 32'(orphan_rsp_o), 32'd0);
    step();

    // Orphan response with empty FIFO: sticky flag until reset
    eu_r_valid_i = 1'b1; eu_r_rdata_i = 32'hD; eu_r_id_i = 5'd1;
    @(negedge clk);
    check("orphan_no_valid", 32'(plug_r_valid_o), 32'd0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("orphan_sticky", 32'(orphan_rsp_o), 32'd1);
      step();
    end
    do_reset();
    @(negedge clk);
    check("orphan_cleared", 32'(orphan_rsp_o), 32'd0);

    // Reset with one outstanding: late response is orphan, pointer back to 0
    plug_req_i = 2'b01; eu_gnt_i = 1'b1;
    push_gnt(2'b01, 0);
    step();
    idle();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    eu_r_valid_i = 1'b1; eu_r_rdata_i = 32'hE; eu_r_id_i = 5'd3;
    plug_req_i = 2'b11; eu_gnt_i = 1'b1;
    push_gnt(2'b01, 0);
    @(negedge clk);
    check("post_reset_no_valid", 32'(plug_r_valid_o), 32'd0);
    step();
    idle();
    eu_r_valid_i = 1'b1; eu_r_rdata_i = 32'hF; eu_r_id_i = 5'd3;
    push_rsp(2'b01, 32'hF, 5'd3);
    @(negedge clk);
    check("post_reset_orphan", 32'(orphan_rsp_o), 32'd1);
    step();
    idle();
    step();
    step();

    check("gnt_queue_empty", 32'(gq.size()), 32'd0);
    check("rsp_queue_empty", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eu_speriph_plug_arbiter.md
Name: eu_speriph_plug_arbiter

Overview:
- Upstream stage of the cluster event unit's single peripheral slave port.
- Merges NB_PLUGS peripheral-interconnect plugs into that one port.
- Arbitrates plug requests round-robin and forwards the winner.
- Records which plug owns each issued transaction and routes read/write responses back only to that plug, so simultaneous plug requests are never merged.

Parameters:
- NB_PLUGS, 2, number of upstream speriph plugs (2..4).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- ID_WIDTH, 5, transaction ID width (NB_CORES+1).
- MAX_OUTSTANDING, 2, depth of the response-ownership FIFO (power of two, >=1).

Ports:
- clk_i  in  1  cluster clock
- rst_ni  in  1  reset, synchronous, active-low
- plug_req_i  in  NB_PLUGS  per-plug request
- plug_add_i  in  NB_PLUGS x ADDR_WIDTH  per-plug address
- plug_wen_i  in  NB_PLUGS  per-plug write-enable-n (1 = read)
- plug_wdata_i  in  NB_PLUGS x DATA_WIDTH  per-plug write data
- plug_be_i  in  NB_PLUGS x DATA_WIDTH/8  per-plug byte enables
- plug_id_i  in  NB_PLUGS x ID_WIDTH  per-plug ID
- plug_gnt_o  out  NB_PLUGS  per-plug grant
- plug_r_valid_o  out  NB_PLUGS  per-plug response valid
- plug_r_rdata_o  out  NB_PLUGS x DATA_WIDTH  response data, broadcast to all plugs
- plug_r_opc_o  out  NB_PLUGS  response error flag, broadcast to all plugs
- plug_r_id_o  out  NB_PLUGS x ID_WIDTH  response ID, broadcast to all plugs
- eu_req_o, eu_add_o, eu_wen_o, eu_wdata_o, eu_be_o, eu_id_o  out  (same widths as plug side)  request to event unit
- eu_gnt_i  in  1  event unit grant
- eu_r_valid_i  in  1  event unit response valid
- eu_r_rdata_i  in  DATA_WIDTH  event unit response data
- eu_r_opc_i  in  1  event unit response error flag
- eu_r_id_i  in  ID_WIDTH  event unit response ID
- orphan_rsp_o  out  1  sticky flag: a response arrived with no owner recorded

Behaviour:
- Clocking/reset: single clock clk_i; reset rst_ni is synchronous active-low, sampled on the rising edge.
- Reset values: rr_ptr=0, FIFO empty (wr_ptr=rd_ptr=0, count=0), orphan_rsp_o=0.
- Reset combinational consequences: plug_gnt_o=0 and eu_req_o=0 while FIFO is full (never at reset); plug_r_valid_o=0 while eu_r_valid_i=0.
- Arbitration (combinational):
  - Winner = first requesting plug at or after rr_ptr, searching upward with wrap-around.
  - eu_req_o = |plug_req_i AND NOT fifo_full_blocking.
  - eu_add/wen/wdata/be/id = winner's fields; all zero when no request.
- Grant: plug_gnt_o[winner] = eu_gnt_i AND eu_req_o; all other grants 0. A handshake (hs) is eu_req_o & eu_gnt_i.
- Round-robin update: on hs, rr_ptr <= (winner+1) mod NB_PLUGS. Otherwise rr_ptr holds. A losing plug is served within NB_PLUGS-1 further handshakes.
- Request stability: plugs hold request fields until granted. The arbiter must not switch winner while eu_req_o=1 and eu_gnt_i=0; winner is locked via a registered lock flag plus locked index.
- Ownership FIFO:
  - On hs, push winner index.
  - On eu_r_valid_i with count>0, pop the head.
  - Push and pop in the same cycle is allowed; count unchanged.
  - fifo_full_blocking = (count==MAX_OUTSTANDING) AND NOT (eu_r_valid_i). Simultaneous pop frees the slot in the same cycle.
- Response routing (zero latency):
  - plug_r_valid_o[head] = eu_r_valid_i when count>0; all others 0.
  - rdata/opc/id are broadcast unmodified to all plugs.
- Orphan response: eu_r_valid_i with count==0 → no plug_r_valid_o, orphan_rsp_o <= 1 (sticky until reset). FIFO is unchanged.
- Same-cycle hs with count==0 plus response: treat the response as orphan; the new hs pushes normally.
- Reset mid-transaction: FIFO flushed. Any in-flight response arriving after reset is orphan.

Test Plan:
- Reset, plug0 read add=0x1B20_0400 id=3, EU grants same cycle, r_valid next cycle rdata=0xDEAD_BEEF → plug_gnt_o=01, then plug_r_valid_o=01 with rdata 0xDEAD_BEEF, id 3; plug1 never sees r_valid.
- Both plugs request continuously, eu_gnt_i=1, EU responds 1 cycle later → grant order 01,10,01,10; each plug_r_valid_o matches grant order one cycle delayed; rr_ptr alternates.
- eu_gnt_i held 0 for 3 cycles while plug0 requests, plug1 joins in cycle 2 → eu_add_o stays plug0's address all 3 cycles; plug0 granted first, plug1 next.
- MAX_OUTSTANDING=2, two hs with no response → eu_req_o=0 and plug_gnt_o=0 despite requests. Response and new request in the same cycle → hs accepted that cycle, count stays 2.
- eu_r_valid_i pulse with FIFO empty → all plug_r_valid_o=0, orphan_rsp_o rises next cycle and stays 1 until rst_ni=0.
- Assert rst_ni=0 for one cycle with 1 outstanding, then response → orphan_rsp_o=1, no plug response, rr_ptr=0 after reset.
